packet_split: RTL and testbench

- Clocked 1-to-2 packet demultiplexer for the NoC. It is the counterpart of the 2-to-1 arbitrated merge.
- Each packet arriving on a single input stream is steered to output 0 or output 1 by one route bit in the packet header.
- Each output has its own FIFO, so a stalled output does not block the other except through the single input hold stage.
- Used at router egress to fan a merged stream back out toward two destinations.

---
 rtl/packet_split.sv | 220 ++++++++++++++++++++++
 tb/tb_packet_split.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_split.sv
// 1-to-2 packet demux: one input hold stage feeding two show-ahead FIFOs.
// Define SPLIT_STATS_EN to add saturating per-output delivery counters.

module packet_split_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             full_o,
    output logic             valid_o,
    output logic             pop_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    assign full_o  = (cnt_q == FULL_CNT);
    assign valid_o = (cnt_q != '0);
    assign pop_o   = valid_o && ready_i;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_o) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_i && pop_o) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so wrap is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_o) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

module packet_split #(
    parameter int WIDTH     = 49,
    parameter int ROUTE_BIT = 48,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef SPLIT_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic             tgt_q;
    logic             tgt_d;
    logic             push;
    logic             tgt_full;
    logic             full0;
    logic             full1;
    logic             pop0;
    logic             pop1;

    // Space is judged on registered counts only; a same-cycle pop
    // does not make room for this cycle's push.
    assign tgt_full = tgt_q ? full1 : full0;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        tgt_d    = tgt_q;
        in_ready = 1'b1;
        push     = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    tgt_d   = in_data[ROUTE_BIT];
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                push     = !tgt_full;
                in_ready = push;
                if (push) begin
                    if (in_valid) begin
                        hold_d = in_data;
                        tgt_d  = in_data[ROUTE_BIT];
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            hold_q  <= '0;
            tgt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tgt_q   <= tgt_d;
        end
    end

    packet_split_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push && !tgt_q),
        .data_i  (hold_q),
        .ready_i (out0_ready),
        .full_o  (full0),
        .valid_o (out0_valid),
        .pop_o   (pop0),
        .data_o  (out0_data)
    );

    packet_split_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push && tgt_q),
        .data_i  (hold_q),
        .ready_i (out1_ready),
        .full_o  (full1),
        .valid_o (out1_valid),
        .pop_o   (pop1),
        .data_o  (out1_data)
    );

`ifdef SPLIT_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt0_d;
    logic [15:0] cnt1_q;
    logic [15:0] cnt1_d;

    // Saturate rather than wrap so a long-running count never lies low.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pop0 && cnt0_q != 16'hFFFF) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (pop1 && cnt1_q != 16'hFFFF) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    logic unused_pops;
    assign unused_pops = pop0 ^ pop1;
`endif

endmodule

// File: tb/tb_packet_split.sv
// Self-checking bench for packet_split against a queue-level model.
// Covers reset, routing, backpressure, head-of-line, wrap, random traffic.

module tb_packet_split;

    localparam int W  = 49;
    localparam int RB = 48;
    localparam int D  = 4;
    localparam int VW = 2 * W + 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out0_valid;
    logic         out0_ready = 1'b0;
    logic [W-1:0] out0_data;
    logic         out1_valid;
    logic         out1_ready = 1'b0;
    logic [W-1:0] out1_data;
`ifdef SPLIT_STATS_EN
    logic [15:0]  cnt0;
    logic [15:0]  cnt1;
`endif

    always #5 clk = ~clk;

    packet_split #(
        .WIDTH     (W),
        .ROUTE_BIT (RB),
        .DEPTH     (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef SPLIT_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: one optional held packet plus two ordered output queues.
    logic [W-1:0] mq0[$];
    logic [W-1:0] mq1[$];
    bit           mheld;
    logic [W-1:0] mhold;
    int           mcnt0;
    int           mcnt1;

    function automatic bit m_rdy();
        if (!mheld) return 1'b1;
        if (mhold[RB]) return mq1.size() < D;
        return mq0.size() < D;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        if (mq0.size() != 0) a = mq0[0];
        if (mq1.size() != 0) b = mq1[0];
        return {m_rdy(), mq0.size() != 0, mq1.size() != 0, a, b};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        logic [W-1:0] z = '0;
        return {in_ready, out0_valid, out1_valid,
                out0_valid ? out0_data : z,
                out1_valid ? out1_data : z};
    endfunction

    function automatic logic [W-1:0] rand_pkt(bit r);
        logic [W-1:0] d;
        d = W'({$urandom(), $urandom()});
        d[RB] = r;
        return d;
    endfunction

    task automatic m_clear();
        mq0.delete();
        mq1.delete();
        mheld = 1'b0;
        mhold = '0;
        mcnt0 = 0;
        mcnt1 = 0;
    endtask

    // Advance one clock: model follows the same edge the DUT sees.
    task automatic step();
        bit           p0;
        bit           p1;
        bit           push;
        bit           acc;
        logic [W-1:0] d;
        p0   = (mq0.size() != 0) && out0_ready;
        p1   = (mq1.size() != 0) && out1_ready;
        push = mheld && m_rdy();
        acc  = in_valid && m_rdy();
        d    = in_data;
        @(posedge clk);
        if (p0) begin
            void'(mq0.pop_front());
            if (mcnt0 < 65535) mcnt0++;
        end
        if (p1) begin
            void'(mq1.pop_front());
            if (mcnt1 < 65535) mcnt1++;
        end
        if (push) begin
            if (mhold[RB]) mq1.push_back(mhold);
            else mq0.push_back(mhold);
        end
        if (acc) begin
            mheld = 1'b1;
            mhold = d;
        end else if (push) begin
            mheld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] want;
        rst_n = 1'b0;
        #12;
        want = {1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}};
        n_chk++;
        if ({in_ready, out0_valid, out1_valid, out0_data, out1_data} !== want) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h",
                     {in_ready, out0_valid, out1_valid, out0_data, out1_data}, want);
        end
`ifdef SPLIT_STATS_EN
        n_chk++;
        if ({cnt0, cnt1} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0", {cnt0, cnt1});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
            end
            step();
        end
    endtask

    task automatic test_routing();
        logic [W-1:0] pk [2];
        pk[0] = 49'h0_0000_0000_00AA;
        pk[1] = 49'h1_0000_0000_00BB;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 2);
            in_data  = (c < 2) ? pk[c] : '0;
            #1;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL routing c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 1 || c == 2) begin
                n_chk++;
                if ({out0_valid, out0_data} !== {c == 2, c == 2 ? pk[0] : out0_data}) begin
                    n_fail++;
                    $display("FAIL route_out0 c%0d: got %b %h want %0d %h",
                             c, out0_valid, out0_data, c == 2, pk[0]);
                end
            end
            if (c == 3) begin
                n_chk++;
                if ({out1_valid, out1_data} !== {1'b1, pk[1]}) begin
                    n_fail++;
                    $display("FAIL route_out1: got %b %h want 1 %h",
                             out1_valid, out1_data, pk[1]);
                end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] pk [6];
        int           idx = 0;
        bit           acc;
        for (int i = 0; i < 6; i++) pk[i] = rand_pkt(1'b0);
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == 12) out0_ready = 1'b1;
            in_valid = (idx < 6);
            in_data  = (idx < 6) ? pk[idx] : '0;
            #1;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL backpressure c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 10) begin
                n_chk++;
                if ({in_ready, out0_valid, out0_data} !== {1'b0, 1'b1, pk[0]}) begin
                    n_fail++;
                    $display("FAIL bp_full: got rdy=%b v=%b %h want rdy=0 v=1 %h",
                             in_ready, out0_valid, out0_data, pk[0]);
                end
            end
            acc = in_valid && m_rdy();
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_chk++;
        if (idx != 6 || mq0.size() != 0 || mheld || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got sent=%0d left=%0d rdy=%b want 6 0 1",
                     idx, mq0.size(), in_ready);
        end
    endtask

    task automatic test_hol();
        int  idx = 0;
        bit  acc;
        bit  took1 = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 14) out0_ready = 1'b1;
            in_valid = (idx < 6);
            in_data  = rand_pkt(idx == 5);
            #1;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hol c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c >= 6 && c < 14) begin
                n_chk++;
                if ({in_ready, out1_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL hol_block c%0d: got rdy=%b v1=%b want 0 0",
                             c, in_ready, out1_valid);
                end
            end
            acc = in_valid && m_rdy();
            if (acc && idx == 5) took1 = 1'b1;
            step();
            if (acc) idx++;
            while (acc && idx < 6 && 0) begin end
        end
        in_valid = 1'b0;
        n_chk++;
        if (!took1 || mq1.size() != 0 || mq0.size() != 0) begin
            n_fail++;
            $display("FAIL hol_end: got took=%b q0=%0d q1=%0d want 1 0 0",
                     took1, mq0.size(), mq1.size());
        end
    endtask

    task automatic test_wrap();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_data  = rand_pkt(1'b1);
            #1;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            n_chk++;
            if (in_ready !== 1'b1 || out1_valid !== (c >= 2 && c < 12)) begin
                n_fail++;
                $display("FAIL wrap_flow c%0d: got rdy=%b v1=%b want 1 %0d",
                         c, in_ready, out1_valid, c >= 2 && c < 12);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        bit pend = 1'b0;
        bit acc;
        for (int c = 0; c < 420; c++) begin
            out0_ready = ($urandom % 4) != 0;
            out1_ready = ($urandom % 3) != 0;
            if (c >= 400) begin
                out0_ready = 1'b1;
                out1_ready = 1'b1;
            end
            if (!pend) begin
                in_valid = (c < 400) && (($urandom % 3) != 0);
                in_data  = rand_pkt(1'($urandom % 2));
            end
            #1;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
`ifdef SPLIT_STATS_EN
            n_chk++;
            if ({cnt0, cnt1} !== {16'(mcnt0), 16'(mcnt1)}) begin
                n_fail++;
                $display("FAIL rand_cnt c%0d: got %h %h want %h %h",
                         c, cnt0, cnt1, 16'(mcnt0), 16'(mcnt1));
            end
`endif
            acc  = in_valid && m_rdy();
            pend = in_valid && !acc;
            step();
        end
        in_valid = 1'b0;
        n_chk++;
        if (mheld || mq0.size() != 0 || mq1.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got q0=%0d q1=%0d want 0 0",
                     mq0.size(), mq1.size());
        end
    endtask

    task automatic test_reset_mid();
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_data  = rand_pkt(1'b0);
            step();
        end
        in_valid = 1'b0;
        n_chk++;
        if (out0_valid !== 1'b1 || mq0.size() != 3) begin
            n_fail++;
            $display("FAIL rst_pre: got v0=%b q0=%0d want 1 3", out0_valid, mq0.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, out0_valid, out1_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_async: got %b want 100", {in_ready, out0_valid, out1_valid});
        end
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
        out0_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rst_after c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            step();
        end
    endtask

`ifdef SPLIT_STATS_EN
    task automatic test_stats();
        int n1;
        int n0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        n1 = mcnt1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5);
            in_data  = rand_pkt(1'b1);
            step();
        end
        n_chk++;
        if (cnt1 !== 16'(n1 + 5) || cnt1 !== 16'(mcnt1)) begin
            n_fail++;
            $display("FAIL cnt1: got %h want %h", cnt1, 16'(n1 + 5));
        end
        n1 = mcnt1;
        n0 = 65535 - mcnt0 + 3;
        for (int c = 0; c < n0 + 3; c++) begin
            in_valid = (c < n0);
            in_data  = rand_pkt(1'b0);
            if (mcnt0 >= 65533) begin
                #1;
                n_chk++;
                if (cnt0 !== 16'(mcnt0)) begin
                    n_fail++;
                    $display("FAIL cnt0_sat c%0d: got %h want %h", c, cnt0, 16'(mcnt0));
                end
            end
            step();
        end
        in_valid = 1'b0;
        n_chk++;
        if ({cnt0, cnt1} !== {16'hFFFF, 16'(n1)}) begin
            n_fail++;
            $display("FAIL cnt_final: got %h %h want ffff %h", cnt0, cnt1, 16'(n1));
        end
    endtask
`endif

    initial begin
        m_clear();
        test_reset();
        test_routing();
        test_backpressure();
        test_hol();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef SPLIT_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
